// File: rtl/ram_dual_port.sv
// Purpose : simple dual-port synchronous RAM (1 write, 1 read port) with a zeroing sweep after reset.
// Latency : write commits on the accepting edge; read data/valid registered, 1 cycle; same-address read is write-first.
// Backpres: none; requests during the init sweep or to addresses >= DEPTH are dropped with a one-cycle err pulse.
//
// Ports:
//   clk, rst                     single clock, synchronous active-high reset
//   wr_enb, wr_addr, wr_data     write request
//   rd_enb, rd_addr              read request
//   rd_data, rd_valid            registered read result, valid for one cycle per accepted read
//   init_busy                    high while the post-reset zeroing sweep runs
//   wr_err, rd_err               one-cycle pulse per dropped request
module ram_dual_port #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_enb,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_enb,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  init_busy,
   output logic                  wr_err,
   output logic                  rd_err
);

   typedef enum logic {ST_INIT, ST_ACTIVE} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
   localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] init_cnt, init_cnt_nxt;
   logic                  wr_in_range, rd_in_range;
   logic                  wr_ok, rd_ok, bypass;
   logic                  rd_valid_nxt, wr_err_nxt, rd_err_nxt;

   assign wr_in_range = {1'b0, wr_addr} < DEPTH_LIM;
   assign rd_in_range = {1'b0, rd_addr} < DEPTH_LIM;

   always_comb begin
      state_nxt    = state;
      init_cnt_nxt = init_cnt;
      wr_ok        = 1'b0;
      rd_ok        = 1'b0;
      case (state)
         ST_INIT: begin
            init_cnt_nxt = init_cnt + 1'b1;
            if (init_cnt == LAST_ADDR) begin
               state_nxt    = ST_ACTIVE;
               init_cnt_nxt = '0;
            end
         end
         ST_ACTIVE: begin
            wr_ok = wr_enb && wr_in_range;
            rd_ok = rd_enb && rd_in_range;
         end
      endcase
      // Anything requested but not accepted is an error, whatever the reason.
      wr_err_nxt   = wr_enb && !wr_ok;
      rd_err_nxt   = rd_enb && !rd_ok;
      rd_valid_nxt = rd_ok;
      bypass       = wr_ok && rd_ok && (wr_addr == rd_addr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_INIT;
         init_cnt  <= '0;
         init_busy <= 1'b1;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         wr_err    <= 1'b0;
         rd_err    <= 1'b0;
      end else begin
         state     <= state_nxt;
         init_cnt  <= init_cnt_nxt;
         init_busy <= (state_nxt == ST_INIT);
         rd_valid  <= rd_valid_nxt;
         wr_err    <= wr_err_nxt;
         rd_err    <= rd_err_nxt;
         // Same-address collision returns the incoming write data (write-first).
         if (rd_ok)
            rd_data <= bypass ? wr_data : mem[rd_addr];
      end
   end

   // Storage has no reset of its own; the init sweep zeroes it one word per edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == ST_INIT)
            mem[init_cnt] <= '0;
         else if (wr_ok)
            mem[wr_addr] <= wr_data;
      end
   end

endmodule

// File: tb/tb_ram_dual_port.sv
// Purpose : self-checking bench for ram_dual_port, default (16-word) and 12-word instances driven in parallel.
// Latency : each step drives one edge of stimulus and compares all outputs 1 time unit after that edge.
// Backpres: not applicable; the bench runs a fixed number of cycles.
module tb_ram_dual_port;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_enb;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       rd_enb;
   logic [3:0] rd_addr;

   logic [7:0] rd_data   [2];
   logic       rd_valid  [2];
   logic       init_busy [2];
   logic       wr_err    [2];
   logic       rd_err    [2];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ram_dual_port u_dut16 (
      .clk(clk), .rst(rst),
      .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_enb(rd_enb), .rd_addr(rd_addr),
      .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .init_busy(init_busy[0]),
      .wr_err(wr_err[0]), .rd_err(rd_err[0])
   );

   ram_dual_port #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12)) u_dut12 (
      .clk(clk), .rst(rst),
      .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_enb(rd_enb), .rd_addr(rd_addr),
      .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .init_busy(init_busy[1]),
      .wr_err(wr_err[1]), .rd_err(rd_err[1])
   );

   // Reference model: one word array per instance plus an init-edges-remaining count.
   int         depth [2] = '{16, 12};
   logic [7:0] mdl_mem [2][16];
   int         init_left [2];
   logic [7:0] e_rd_data [2];
   logic       e_rd_valid [2];
   logic       e_busy [2];
   logic       e_wr_err [2];
   logic       e_rd_err [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input int i, input bit r, input bit we, input int wa,
                             input logic [7:0] wd, input bit re, input int ra);
      bit w_ok, r_ok;
      if (r) begin
         init_left[i]  = depth[i];
         e_busy[i]     = 1'b1;
         e_rd_valid[i] = 1'b0;
         e_rd_data[i]  = 8'h00;
         e_wr_err[i]   = 1'b0;
         e_rd_err[i]   = 1'b0;
         for (int a = 0; a < 16; a++) mdl_mem[i][a] = 8'h00;
      end else if (init_left[i] > 0) begin
         init_left[i]--;
         e_busy[i]     = (init_left[i] != 0);
         e_rd_valid[i] = 1'b0;
         e_wr_err[i]   = we;
         e_rd_err[i]   = re;
      end else begin
         w_ok = we && (wa < depth[i]);
         r_ok = re && (ra < depth[i]);
         e_busy[i]     = 1'b0;
         e_wr_err[i]   = we && !w_ok;
         e_rd_err[i]   = re && !r_ok;
         e_rd_valid[i] = r_ok;
         // Write applied first so a same-address read sees the new data.
         if (w_ok) mdl_mem[i][wa] = wd;
         if (r_ok) e_rd_data[i] = mdl_mem[i][ra];
      end
   endtask

   task automatic step(input bit r, input bit we, input int wa, input logic [7:0] wd,
                       input bit re, input int ra);
      rst     = r;
      wr_enb  = we;
      wr_addr = 4'(wa);
      wr_data = wd;
      rd_enb  = re;
      rd_addr = 4'(ra);
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_edge(i, r, we, wa, wd, re, ra);
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rd_data[%0d]", i),   32'(rd_data[i]),   32'(e_rd_data[i]));
         check($sformatf("rd_valid[%0d]", i),  32'(rd_valid[i]),  32'(e_rd_valid[i]));
         check($sformatf("init_busy[%0d]", i), 32'(init_busy[i]), 32'(e_busy[i]));
         check($sformatf("wr_err[%0d]", i),    32'(wr_err[i]),    32'(e_wr_err[i]));
         check($sformatf("rd_err[%0d]", i),    32'(rd_err[i]),    32'(e_rd_err[i]));
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 8'h00, 0, 0);
   endtask

   task automatic read_all();
      for (int a = 0; a < 16; a++) step(0, 0, 0, 8'h00, 1, a);
   endtask

   initial begin
      int         busy_cnt [2];
      logic [7:0] held;

      rst = 1'b1; wr_enb = 1'b0; wr_addr = '0; wr_data = '0; rd_enb = 1'b0; rd_addr = '0;

      // Reset then idle: count edges with init_busy high after rst falls.
      step(1, 0, 0, 8'h00, 0, 0);
      step(1, 0, 0, 8'h00, 0, 0);
      busy_cnt = '{0, 0};
      for (int k = 0; k < 20; k++) begin
         for (int i = 0; i < 2; i++) if (init_busy[i]) busy_cnt[i]++;
         idle(1);
      end
      check("init_len16", 32'(busy_cnt[0]), 32'd16);
      check("init_len12", 32'(busy_cnt[1]), 32'd12);
      read_all();

      // Write then read the next cycle.
      step(0, 1, 3, 8'hA5, 0, 0);
      step(0, 0, 0, 8'h00, 1, 3);
      check("wr_rd_a5", 32'(rd_data[0]), 32'hA5);

      // Same-cycle collision on address 7, old content 0x11.
      step(0, 1, 7, 8'h11, 0, 0);
      step(0, 1, 7, 8'h3C, 1, 7);
      check("bypass_3c", 32'(rd_data[0]), 32'h3C);
      step(0, 0, 0, 8'h00, 1, 7);
      check("later_3c", 32'(rd_data[0]), 32'h3C);

      // Out-of-range for the 12-word instance: write 13, read 14.
      held = rd_data[1];
      step(0, 1, 13, 8'hEE, 1, 14);
      check("oob_rd_hold", 32'(rd_data[1]), 32'(held));
      check("oob_wr_err", 32'(wr_err[1]), 32'd1);
      idle(1);
      check("oob_err_pulse", 32'(wr_err[1]), 32'd0);
      read_all();

      // Request during INIT, two cycles after rst falls.
      step(1, 0, 0, 8'h00, 0, 0);
      idle(1);
      step(0, 1, 0, 8'hFF, 0, 0);
      check("init_wr_err", 32'(wr_err[0]), 32'd1);
      idle(16);
      step(0, 0, 0, 8'h00, 1, 0);
      check("init_wr_dropped", 32'(rd_data[0]), 32'h00);

      // Reset mid-operation with a read in flight.
      for (int a = 0; a < 16; a++) step(0, 1, a, 8'h5A, 0, 0);
      step(0, 0, 0, 8'h00, 1, 2);
      check("midop_read", 32'(rd_data[0]), 32'h5A);
      step(1, 0, 0, 8'h00, 0, 0);
      check("midop_rd_valid", 32'(rd_valid[0]), 32'd0);
      idle(16);
      read_all();

      // Random traffic with occasional resets.
      for (int k = 0; k < 400; k++) begin
         step($urandom_range(0, 99) == 0,
              1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 8'($urandom),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
